// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter: FSM state
// encoding, parameter limits and counter sizing.
package uart_pkg;

  localparam int DATA_W_MIN       = 5;
  localparam int DATA_W_MAX       = 9;
  localparam int CLKS_PER_BIT_MIN = 2;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;

  // Wide enough to index DATA_W_MAX data bits or STOP_BITS_MAX stop bits.
  localparam int BIT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, with a sync clear
// and a one-cycle tick on the last count of each bit period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr || (r_cnt == LAST_CNT)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST_CNT) && !i_clr;

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter (start, DATA_W bits LSB first, optional
// parity, STOP_BITS stop bits). Parity is compiled in with UART_TX_PARITY_EN.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("uart_tx_param: DATA_W=%0d outside %0d..%0d", DATA_W, DATA_W_MIN, DATA_W_MAX);
  end
  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT=%0d below %0d", CLKS_PER_BIT, CLKS_PER_BIT_MIN);
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS=%0d must be 1 or 2", STOP_BITS);
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx_param: PARITY_ODD=%0d must be 0 or 1", PARITY_ODD);
  end

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  uart_state_e r_state, w_state_nxt;
  logic [DATA_W-1:0]    r_shift;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic w_tick, w_load, w_shift, w_bit_inc, w_bit_clr, w_baud_clr;

`ifdef UART_TX_PARITY_EN
  logic r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= (^din) ^ (PARITY_ODD == 1);
    end
  end
`endif

  // Counter held in clear while idle, so every frame starts from count 0.
  assign w_baud_clr = (r_state == ST_IDLE);
  assign dbg_state  = r_state;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_baud_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_load) begin
        r_shift <= din;
      end else if (w_shift) begin
        r_shift <= {1'b0, r_shift[DATA_W-1:1]};
      end
      if (w_load || w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_bit_inc   = 1'b0;
    w_bit_clr   = 1'b0;
    tx          = 1'b1;
    ready       = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (w_tick) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx = r_shift[0];
        if (w_tick) begin
          w_shift = 1'b1;
          if (r_bit_cnt == LAST_DATA) begin
            w_bit_clr = 1'b1;
`ifdef UART_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx = r_parity;
        if (w_tick) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == LAST_STOP) begin
            done        = 1'b1;
            w_bit_clr   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: two instances (1 stop/even parity, 2 stops/odd
// parity) checked cycle by cycle against a bit-list frame model.
module tb_uart_tx_param;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;
  logic [DW-1:0] din_a = '0, din_b = '0;
  logic valid_a = 1'b0, valid_b = 1'b0;
  logic ready_a, tx_a, busy_a, done_a;
  logic ready_b, tx_b, busy_b, done_b;
  logic [2:0] st_a, st_b;
  logic w_ready, w_tx, w_busy, w_done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .valid(valid_a), .ready(ready_a),
    .tx(tx_a), .busy(busy_a), .done(done_a), .dbg_state(st_a)
  );

  uart_tx_param #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .valid(valid_b), .ready(ready_b),
    .tx(tx_b), .busy(busy_b), .done(done_b), .dbg_state(st_b)
  );

  assign w_ready = sel ? ready_b : ready_a;
  assign w_tx    = sel ? tx_b    : tx_a;
  assign w_busy  = sel ? busy_b  : busy_a;
  assign w_done  = sel ? done_b  : done_a;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [DW-1:0] d);
    if (sel) begin
      valid_b = v;
      din_b   = d;
    end else begin
      valid_a = v;
      din_a   = d;
    end
  endtask

  // Called at a negedge with the selected DUT idle. vmode: 0 = single request,
  // 1 = valid held high through the frame, 2 = extra valid pulse mid-frame.
  task automatic run_frame(input logic [DW-1:0] d, input int vmode,
                           input logic [DW-1:0] d2, output int acc_cyc,
                           output int busy_cnt);
    logic exp_q[$];
    int stops, len, done_cnt;
    logic odd, v;
    stops    = sel ? 2 : 1;
    odd      = sel;
    busy_cnt = 0;
    done_cnt = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (PB == 1) exp_q.push_back((^d) ^ odd);
    for (int s = 0; s < stops; s++) exp_q.push_back(1'b1);
    len = exp_q.size() * CPB;

    chk("ready_before_accept", w_ready, 1);
    set_in(1'b1, d);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      chk("tx_bit", w_tx, exp_q[(k - 1) / CPB]);
      chk("done", w_done, (k == len) ? 1 : 0);
      chk("ready_busy", w_ready, 0);
      if (w_busy === 1'b1) busy_cnt++;
      if (w_done === 1'b1) done_cnt++;
      v = (vmode == 1) || (vmode == 2 && k == 8);
      set_in(v, (k >= len / 2) ? d2 : d);
    end
    @(negedge clk);
    chk("ready_after", w_ready, 1);
    chk("busy_after", w_busy, 0);
    chk("tx_after", w_tx, 1);
    chk("busy_cycles", busy_cnt, len);
    chk("done_pulses", done_cnt, 1);
    if (vmode != 1) begin
      set_in(1'b0, d2);
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        chk("idle_busy", w_busy, 0);
        chk("idle_tx", w_tx, 1);
      end
    end
  endtask

  initial begin
    int a0, a1, bc;
    logic [DW-1:0] d, d2;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    chk("rst_tx_a", tx_a, 1);
    chk("rst_ready_a", ready_a, 1);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_tx_b", tx_b, 1);
    chk("rst_ready_b", ready_b, 1);
    rst = 1'b0;

    // First accept on the first edge after reset release; 0xC3 reference frame.
    run_frame(8'hC3, 0, 8'h3C, a0, bc);
    chk("frame_len_a", bc, (10 + PB) * CPB);

    // valid held high: second frame follows one idle cycle later.
    run_frame(8'hA5, 1, 8'h5A, a0, bc);
    run_frame(8'h5A, 0, 8'hFF, a1, bc);
    chk("b2b_spacing", a1 - a0, (10 + PB) * CPB + 1);

    // Valid pulse while busy is ignored.
    run_frame(8'h96, 2, 8'h69, a0, bc);

    // Two stop bits, odd parity.
    sel = 1'b1;
    run_frame(8'h00, 0, 8'hFF, a0, bc);
    chk("frame_len_b", bc, (11 + PB) * CPB);
    run_frame(8'hC3, 0, 8'h00, a0, bc);

    // Async reset during data bit 3 (0xF7 has bit 3 low).
    sel = 1'b0;
    d = 8'hF7;
    set_in(1'b1, d);
    @(posedge clk);
    #1;
    set_in(1'b0, d);
    repeat (18) @(negedge clk);
    chk("pre_rst_tx", w_tx, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_tx", w_tx, 1);
    chk("rst_mid_ready", w_ready, 1);
    chk("rst_mid_busy", w_busy, 0);
    chk("rst_mid_done", w_done, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_done", w_done, 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(8'h3C, 0, 8'hAA, a0, bc);

    for (int n = 0; n < 10; n++) begin
      sel = n[0];
      d   = DW'($urandom_range(0, 255));
      d2  = DW'($urandom_range(0, 255));
      run_frame(d, ($urandom_range(0, 1) == 1) ? 2 : 0, d2, a0, bc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
